// File: rtl/y_pc_stage.sv
// Program-counter stage: holds the fetch PC, selects the next PC from one of four
// sources per transfer, buffers one redirect while stalled. Optional: Y_PC_REDIR_COUNT_EN.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | first cycle after reset, pc not yet offered to fetch
//   ST_RUN  | pc offered to fetch, advances on each accepted transfer
//   ST_TRAP | one-cycle misaligned-target trap, pc parked at TRAP_VEC
module y_pc_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc,
  output logic        pc_valid,
  input  logic        pc_ready,
  input  logic        redir_valid,
  input  logic [1:0]  redir_sel,
  input  logic [15:0] redir_imm,
  input  logic [25:0] redir_tgt,
  input  logic [31:0] redir_reg,
  output logic        trap
`ifdef Y_PC_REDIR_COUNT_EN
  ,
  output logic [15:0] redir_count
`endif
);

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_BR  = 2'b01;
  localparam logic [1:0] SEL_JMP = 2'b10;
  localparam logic [1:0] SEL_REG = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;

  logic        pend_vld_q, pend_vld_d;
  logic [1:0]  pend_sel_q, pend_sel_d;
  logic [15:0] pend_imm_q, pend_imm_d;
  logic [25:0] pend_tgt_q, pend_tgt_d;
  logic [31:0] pend_reg_q, pend_reg_d;

  logic        xfer;
  logic        misalign;
  logic [1:0]  src_sel;
  logic [15:0] src_imm;
  logic [25:0] src_tgt;
  logic [31:0] src_reg;
  logic [31:0] p4;
  logic [31:0] br_off;
  logic [31:0] next_pc;

  assign pc_valid = (state_q == ST_RUN);
  assign trap     = (state_q == ST_TRAP);
  assign pc       = pc_q;
  assign xfer     = pc_valid && pc_ready;

  // A live redirect always beats the buffered one; with neither, go sequential.
  always_comb begin
    src_sel = SEL_SEQ;
    src_imm = 16'h0000;
    src_tgt = 26'h000_0000;
    src_reg = 32'h0000_0000;
    if (redir_valid) begin
      src_sel = redir_sel;
      src_imm = redir_imm;
      src_tgt = redir_tgt;
      src_reg = redir_reg;
    end else if (pend_vld_q) begin
      src_sel = pend_sel_q;
      src_imm = pend_imm_q;
      src_tgt = pend_tgt_q;
      src_reg = pend_reg_q;
    end
  end

  // Arithmetic is relative to the pc being transferred now, not when buffered.
  always_comb begin
    p4      = pc_q + 32'd4;
    br_off  = {{14{src_imm[15]}}, src_imm, 2'b00};
    next_pc = p4;
    unique case (src_sel)
      SEL_SEQ: next_pc = p4;
      SEL_BR:  next_pc = p4 + br_off;
      SEL_JMP: next_pc = {p4[31:28], src_tgt, 2'b00};
      SEL_REG: next_pc = src_reg;
      default: next_pc = p4;
    endcase
    misalign = |next_pc[1:0];
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_vld_d = pend_vld_q;
    pend_sel_d = pend_sel_q;
    pend_imm_d = pend_imm_q;
    pend_tgt_d = pend_tgt_q;
    pend_reg_d = pend_reg_q;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_RUN;
        if (redir_valid) begin
          pend_vld_d = 1'b1;
          pend_sel_d = redir_sel;
          pend_imm_d = redir_imm;
          pend_tgt_d = redir_tgt;
          pend_reg_d = redir_reg;
        end
      end
      ST_RUN: begin
        if (xfer) begin
          pend_vld_d = 1'b0;
          if (misalign) begin
            state_d = ST_TRAP;
            pc_d    = TRAP_VEC;
          end else begin
            pc_d    = next_pc;
          end
        end else if (redir_valid) begin
          pend_vld_d = 1'b1;
          pend_sel_d = redir_sel;
          pend_imm_d = redir_imm;
          pend_tgt_d = redir_tgt;
          pend_reg_d = redir_reg;
        end
      end
      ST_TRAP: begin
        // redirects arriving here are intentionally dropped
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      pend_vld_q <= 1'b0;
      pend_sel_q <= SEL_SEQ;
      pend_imm_q <= 16'h0000;
      pend_tgt_q <= 26'h000_0000;
      pend_reg_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_vld_q <= pend_vld_d;
      pend_sel_q <= pend_sel_d;
      pend_imm_q <= pend_imm_d;
      pend_tgt_q <= pend_tgt_d;
      pend_reg_q <= pend_reg_d;
    end
  end

`ifdef Y_PC_REDIR_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Counts taken non-sequential transfers; a trapping transfer is not counted.
  always_comb begin
    cnt_d = cnt_q;
    if (xfer && !misalign && (src_sel != SEL_SEQ) && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'h0000;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign redir_count = cnt_q;
`endif

endmodule
